ahb_arbiter: RTL and testbench

AHB_ARBITER -- requirements
Module: ahb_arbiter

---
 rtl/ahb_arbiter_pkg.sv | 15 +
 rtl/ahb_arbiter_picker.sv | 24 ++
 rtl/ahb_arbiter.sv | 121 ++++++++++++
 tb/tb_ahb_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_arbiter_pkg.sv
// p_hardisc: shared AHB constants and response-buffer entry type used by ahb_arbiter
package p_hardisc;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam int         CSUM_W        = 7;

    // control half of a parked response; the data word is sized by the instance
    typedef struct packed {
        logic              full;
        logic              resp;
        logic [CSUM_W-1:0] csum;
    } rsp_buf_t;

endpackage

// File: rtl/ahb_arbiter_picker.sv
// arbiter_picker: one-hot winner among masked requests, highest priority starting at ptr
module arbiter_picker #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  mask,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant
);

    logic [IW-1:0] k;

    // scan offsets from farthest to nearest so the candidate closest to ptr is written last
    always_comb begin
        grant = '0;
        k     = '0;
        for (int i = N - 1; i >= 0; i--) begin
            k     = IW'((int'(ptr) + i) % N);
            grant = (req[k] && mask[k]) ? N'(1) << k : grant;
        end
    end

endmodule

// File: rtl/ahb_arbiter.sv
// ahb_arbiter: N-to-1 AHB-Lite arbiter with zero-latency grant and per-channel response buffer
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise fixed priority (ch0 highest).
module ahb_arbiter
    import p_hardisc::*;
#(
    parameter int CHANNELS = 2,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32
) (
    input  logic                            s_clk_i,
    input  logic                            s_resetn_i,
    input  logic [CHANNELS-1:0][ADDR_W-1:0] s_m_haddr_i,
    input  logic [CHANNELS-1:0][1:0]        s_m_htrans_i,
    input  logic [CHANNELS-1:0]             s_m_hwrite_i,
    input  logic [CHANNELS-1:0][2:0]        s_m_hsize_i,
    input  logic [CHANNELS-1:0]             s_m_hmastlock_i,
    input  logic [CHANNELS-1:0][DATA_W-1:0] s_m_hwdata_i,
    input  logic [CHANNELS-1:0][CSUM_W-1:0] s_m_hwchecksum_i,
    output logic [CHANNELS-1:0][DATA_W-1:0] s_m_hrdata_o,
    output logic [CHANNELS-1:0][CSUM_W-1:0] s_m_hrchecksum_o,
    output logic [CHANNELS-1:0]             s_m_hready_o,
    output logic [CHANNELS-1:0]             s_m_hresp_o,
    output logic [ADDR_W-1:0]               s_haddr_o,
    output logic [1:0]                      s_htrans_o,
    output logic                            s_hwrite_o,
    output logic [2:0]                      s_hsize_o,
    output logic                            s_hmastlock_o,
    output logic [DATA_W-1:0]               s_hwdata_o,
    output logic [CSUM_W-1:0]               s_hwchecksum_o,
    input  logic [DATA_W-1:0]               s_hrdata_i,
    input  logic [CSUM_W-1:0]               s_hrchecksum_i,
    input  logic                            s_hready_i,
    input  logic                            s_hresp_i,
    output logic [CHANNELS-1:0]             s_grant_o
);

    localparam int IW = CHANNELS > 1 ? $clog2(CHANNELS) : 1;

    logic [CHANNELS-1:0] req, mask, owned;
    logic [IW-1:0]       gi, ptr, dp_owner;
    logic                gnt, dp_valid, lock_q;
    logic [ADDR_W-1:0]   haddr_q;

    assign mask = lock_q ? CHANNELS'(1) << dp_owner : '1;
    assign gnt  = |s_grant_o;

    arbiter_picker #(.N(CHANNELS), .IW(IW)) u_picker (
        .req   (req),
        .mask  (mask),
        .ptr   (ptr),
        .grant (s_grant_o)
    );

    // binary index of the one-hot grant
    always_comb begin
        gi = '0;
        for (int i = 0; i < CHANNELS; i++) gi = s_grant_o[i] ? IW'(i) : gi;
    end

`ifdef ARB_ROUND_ROBIN_EN
    // rotate priority past the winner each time an address phase is accepted
    always_ff @(posedge s_clk_i or negedge s_resetn_i)
        if (!s_resetn_i) ptr <= '0;
        else if (s_hready_i && gnt) ptr <= IW'((int'(gi) + 1) % CHANNELS);
`else
    assign ptr = '0;
`endif

    // granted master drives the address phase directly; an idle bus parks on the last address
    always_comb begin
        s_htrans_o     = gnt ? s_m_htrans_i[gi] : HTRANS_IDLE;
        s_haddr_o      = gnt ? s_m_haddr_i[gi] : haddr_q;
        s_hwrite_o     = gnt && s_m_hwrite_i[gi];
        s_hsize_o      = gnt ? s_m_hsize_i[gi] : 3'd0;
        s_hmastlock_o  = gnt && s_m_hmastlock_i[gi];
        s_hwdata_o     = dp_valid ? s_m_hwdata_i[dp_owner] : '0;
        s_hwchecksum_o = dp_valid ? s_m_hwchecksum_i[dp_owner] : '0;
    end

    // accepted address phase becomes the data phase; an idle bus also releases any lock
    always_ff @(posedge s_clk_i or negedge s_resetn_i)
        if (!s_resetn_i) begin
            dp_valid <= 1'b0;
            dp_owner <= '0;
            lock_q   <= 1'b0;
            haddr_q  <= '0;
        end else begin
            if (gnt) haddr_q <= s_haddr_o;
            if (s_hready_i) begin
                dp_valid <= gnt;
                dp_owner <= gnt ? gi : dp_owner;
                lock_q   <= gnt && s_m_hmastlock_i[gi];
            end
        end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        rsp_buf_t          ent;
        logic [DATA_W-1:0] ent_data;
        logic              cap;
        assign req[c]              = |(s_m_htrans_i[c] & HTRANS_NONSEQ);
        assign owned[c]            = dp_valid && dp_owner == IW'(c);
        assign cap                 = owned[c] && s_hready_i && req[c] && !s_grant_o[c];
        assign s_m_hready_o[c]     = owned[c] ? s_hready_i && (!req[c] || s_grant_o[c])
                                              : !req[c] || (s_grant_o[c] && s_hready_i);
        assign s_m_hrdata_o[c]     = ent.full ? ent_data : s_hrdata_i;
        assign s_m_hrchecksum_o[c] = ent.full ? ent.csum : s_hrchecksum_i;
        assign s_m_hresp_o[c]      = ent.full ? ent.resp : owned[c] && s_hresp_i;
        // park the response of an owner that lost the next address phase until it is accepted
        always_ff @(posedge s_clk_i or negedge s_resetn_i)
            if (!s_resetn_i) begin
                ent      <= '0;
                ent_data <= '0;
            end else if (cap) begin
                ent      <= '{full: 1'b1, resp: s_hresp_i, csum: s_hrchecksum_i};
                ent_data <= s_hrdata_i;
            end else if (ent.full && s_m_hready_o[c]) begin
                ent.full <= 1'b0;
            end
    end

endmodule

// File: tb/tb_ahb_arbiter.sv
// tb_ahb_arbiter: directed scenarios plus randomized traffic checked against a cycle model
module tb_ahb_arbiter;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n;
    logic [N-1:0][AW-1:0] m_haddr;
    logic [N-1:0][1:0]    m_htrans;
    logic [N-1:0]         m_hwrite;
    logic [N-1:0][2:0]    m_hsize;
    logic [N-1:0]         m_hlock;
    logic [N-1:0][DW-1:0] m_hwdata;
    logic [N-1:0][6:0]    m_hwcs;
    logic [N-1:0][DW-1:0] m_hrdata;
    logic [N-1:0][6:0]    m_hrcs;
    logic [N-1:0]         m_hready;
    logic [N-1:0]         m_hresp;
    logic [AW-1:0]        haddr;
    logic [1:0]           htrans;
    logic                 hwrite;
    logic [2:0]           hsize;
    logic                 hlock;
    logic [DW-1:0]        hwdata;
    logic [6:0]           hwcs;
    logic [DW-1:0]        hrdata;
    logic [6:0]           hrcs;
    logic                 hready;
    logic                 hresp;
    logic [N-1:0]         grant;

    int n_tests = 0;
    int n_fail  = 0;

    // model state: data-phase owner, lock, rotation pointer, parked address, response buffers
    bit            mv;
    int            mo;
    bit            ml;
    int            mp;
    logic [AW-1:0] mlast;
    bit            mf[N];
    logic [DW-1:0] md[N];
    logic [6:0]    mc[N];
    bit            mr[N];

    always #5 clk = ~clk;

    ahb_arbiter #(.CHANNELS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .s_clk_i          (clk),
        .s_resetn_i       (rst_n),
        .s_m_haddr_i      (m_haddr),
        .s_m_htrans_i     (m_htrans),
        .s_m_hwrite_i     (m_hwrite),
        .s_m_hsize_i      (m_hsize),
        .s_m_hmastlock_i  (m_hlock),
        .s_m_hwdata_i     (m_hwdata),
        .s_m_hwchecksum_i (m_hwcs),
        .s_m_hrdata_o     (m_hrdata),
        .s_m_hrchecksum_o (m_hrcs),
        .s_m_hready_o     (m_hready),
        .s_m_hresp_o      (m_hresp),
        .s_haddr_o        (haddr),
        .s_htrans_o       (htrans),
        .s_hwrite_o       (hwrite),
        .s_hsize_o        (hsize),
        .s_hmastlock_o    (hlock),
        .s_hwdata_o       (hwdata),
        .s_hwchecksum_o   (hwcs),
        .s_hrdata_i       (hrdata),
        .s_hrchecksum_i   (hrcs),
        .s_hready_i       (hready),
        .s_hresp_i        (hresp),
        .s_grant_o        (grant)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mv = 0; mo = 0; ml = 0; mp = 0; mlast = '0;
        for (int c = 0; c < N; c++) mf[c] = 0;
    endtask

    // compare every output with the model for this cycle, then advance the model one edge
    task automatic model();
        int w = -1;
        bit rq, g, own;
        bit rdy[N];
        for (int k = 0; k < N; k++) begin
            int c = (mp + k) % N;
            if (w < 0 && m_htrans[c][1] && (!ml || c == mo)) w = c;
        end
        chk("grant", grant, w < 0 ? 0 : (1 << w));
        chk("htrans", htrans, w < 0 ? 0 : m_htrans[w]);
        chk("haddr", haddr, w < 0 ? mlast : m_haddr[w]);
        chk("hwrite", hwrite, w >= 0 && m_hwrite[w]);
        chk("hsize", hsize, w < 0 ? 0 : m_hsize[w]);
        chk("hmastlock", hlock, w >= 0 && m_hlock[w]);
        chk("hwdata", hwdata, mv ? m_hwdata[mo] : 0);
        chk("hwchecksum", hwcs, mv ? m_hwcs[mo] : 0);
        for (int c = 0; c < N; c++) begin
            rq  = m_htrans[c][1];
            g   = (w == c);
            own = mv && mo == c;
            rdy[c] = own ? hready && (!rq || g) : !rq || (g && hready);
            chk($sformatf("hready%0d", c), m_hready[c], rdy[c]);
            chk($sformatf("hresp%0d", c), m_hresp[c], mf[c] ? mr[c] : (own && hresp));
            if (mf[c] || own) begin
                chk($sformatf("hrdata%0d", c), m_hrdata[c], mf[c] ? md[c] : hrdata);
                chk($sformatf("hrchecksum%0d", c), m_hrcs[c], mf[c] ? mc[c] : hrcs);
            end
        end
        for (int c = 0; c < N; c++) begin
            if (mf[c] && rdy[c]) mf[c] = 0;
            if (mv && mo == c && hready && m_htrans[c][1] && w != c) begin
                mf[c] = 1; md[c] = hrdata; mc[c] = hrcs; mr[c] = hresp;
            end
        end
        if (w >= 0) mlast = m_haddr[w];
        if (hready) begin
            mv = (w >= 0);
            ml = (w >= 0) && m_hlock[w];
            if (w >= 0) begin
                mo = w;
`ifdef ARB_ROUND_ROBIN_EN
                mp = (w + 1) % N;
`endif
            end
        end
    endtask

    task automatic idle();
        m_htrans = '0; m_hlock = '0; m_hwrite = '0; m_hsize = '0;
        m_haddr = '0; m_hwdata = '0; m_hwcs = '0;
        hready = 1'b1; hresp = 1'b0; hrdata = '0; hrcs = '0;
    endtask

    task automatic req_ch(input int c, input logic [AW-1:0] a, input logic lk);
        m_htrans[c] = 2'b10; m_haddr[c] = a; m_hlock[c] = lk;
        m_hwdata[c] = $urandom; m_hwcs[c] = 7'($urandom);
    endtask

    task automatic sample();
        @(negedge clk);
        model();
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic assert_reset();
        idle();
        rst_n = 1'b0;
        model_reset();
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        adv();
    endtask

    task automatic chk_reset(input string t);
        chk({t, " grant"}, grant, 0);
        chk({t, " htrans"}, htrans, 0);
        chk({t, " haddr"}, haddr, 0);
        chk({t, " hready"}, m_hready, 2'b11);
        chk({t, " hresp"}, m_hresp, 0);
        chk({t, " hwdata"}, hwdata, 0);
    endtask

    initial begin
        int b, o;
`ifdef ARB_ROUND_ROBIN_EN
        b = 0;
`else
        b = 1;
`endif
        o = 1 - b;
        assert_reset();
        chk_reset("reset");
        release_reset();

        // single read with one wait state
        req_ch(0, 'h100, 0);
        sample();
        chk("031 grant", grant, 1);
        chk("031 haddr", haddr, 'h100);
        chk("031 htrans", htrans, 2'b10);
        adv(); idle(); hready = 1'b0;
        sample();
        chk("031 wait", m_hready[0], 0);
        adv(); hready = 1'b1; hrdata = 'hDEADBEEF;
        sample();
        chk("031 rdata", m_hrdata[0], 'hDEADBEEF);
        chk("031 ready", m_hready[0], 1);
        adv();

        // both masters requesting continuously
        assert_reset(); release_reset();
        req_ch(0, 'h180, 0); req_ch(1, 'h280, 0);
        for (int i = 0; i < 4; i++) begin
            hrdata = $urandom;
            sample();
`ifdef ARB_ROUND_ROBIN_EN
            chk($sformatf("032 grant%0d", i), grant, (i % 2) ? 2 : 1);
`else
            chk($sformatf("032 grant%0d", i), grant, 1);
`endif
            adv();
        end

        // owner loses the next address phase: its read data is parked, then delivered
        assert_reset(); release_reset();
        req_ch(b, 'h300, 0);
        sample(); adv();
        req_ch(b, 'h304, 0); req_ch(o, 'h400, 0); hrdata = 'h12345678;
        sample();
        chk("033 grant other", grant, 1 << o);
        chk("033 held", m_hready[b], 0);
        adv();
        m_htrans[o] = 2'b00; hrdata = '0;
        sample();
        chk("033 grant buf", grant, 1 << b);
        chk("033 ready", m_hready[b], 1);
        chk("033 rdata", m_hrdata[b], 'h12345678);
        adv();

        // reset while a response sits in a buffer
        assert_reset(); release_reset();
        req_ch(b, 'h300, 0);
        sample(); adv();
        req_ch(b, 'h304, 0); req_ch(o, 'h400, 0); hrdata = 'hCAFEF00D;
        sample(); adv();
        assert_reset();
        chk_reset("036");
        chk("036 rdata", m_hrdata[b], 0);
        release_reset();

        // two-cycle error response on ch1
        req_ch(1, 'h500, 0);
        sample();
        chk("034 grant", grant, 2);
        adv(); idle(); hready = 1'b0; hresp = 1'b1;
        sample();
        chk("034 resp1", m_hresp[1], 1);
        chk("034 ready1", m_hready[1], 0);
        chk("034 ch0 resp", m_hresp[0], 0);
        adv(); hready = 1'b1; hresp = 1'b1;
        sample();
        chk("034 resp2", m_hresp[1], 1);
        chk("034 ready2", m_hready[1], 1);
        chk("034 ch0 ready", m_hready[0], 1);
        adv(); idle();

        // locked sequence on ch1 keeps ch0 out until the lock drops
        assert_reset(); release_reset();
        req_ch(1, 'h600, 1);
        sample(); chk("035 grantA", grant, 2); adv();
        req_ch(0, 'h700, 0); req_ch(1, 'h604, 1);
        sample(); chk("035 grantB", grant, 2); adv();
        m_htrans[1] = 2'b00; m_hlock[1] = 1'b0;
        sample(); chk("035 grantC", grant, 0); adv();
        sample(); chk("035 grantD", grant, 1); adv();

        // randomized traffic
        assert_reset(); release_reset();
        for (int i = 0; i < 1500; i++) begin
            for (int c = 0; c < N; c++) begin
                m_htrans[c] = ($urandom_range(0, 2) != 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
                m_haddr[c]  = $urandom;
                m_hlock[c]  = ($urandom_range(0, 3) == 0);
                m_hwrite[c] = 1'($urandom);
                m_hsize[c]  = 3'($urandom);
                m_hwdata[c] = $urandom;
                m_hwcs[c]   = 7'($urandom);
            end
            hready = ($urandom_range(0, 3) != 0);
            hresp  = ($urandom_range(0, 7) == 0);
            hrdata = $urandom;
            hrcs   = 7'($urandom);
            sample();
            adv();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
